// File: rtl/stack_exec_unit.sv
// Operand-stack execution unit: push/drop/ALU ops on TOS/NOS with error reporting.
// Define STACK_EXEC_DIV_EN to build the iterative DIV/MOD divider; otherwise those opcodes are illegal.
module stack_exec_unit #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int OP_W   = 16,
    localparam int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rsp_done,
    output logic [1:0]        rsp_err,
    output logic [DATA_W-1:0] tos,
    output logic [SP_W-1:0]   depth,
    output logic [1:0]        dbg_state
);
    // Handshake: a command is taken on a rising edge with cmd_valid & cmd_ready;
    // cmd_ready is high only in IDLE; rsp_done is a one-cycle pulse per retired command.
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [OP_W-1:0] OP_IGN  = OP_W'(8'h00);
    localparam logic [OP_W-1:0] OP_IMM  = OP_W'(8'h01);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(8'h0b);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(8'h0c);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(8'h0d);
    localparam logic [OP_W-1:0] OP_DIV  = OP_W'(8'h0e);
    localparam logic [OP_W-1:0] OP_MOD  = OP_W'(8'h0f);
    localparam logic [OP_W-1:0] OP_GRET = OP_W'(8'h10);
    localparam logic [OP_W-1:0] OP_LESS = OP_W'(8'h11);
    localparam logic [OP_W-1:0] OP_EQ   = OP_W'(8'h12);
    localparam logic [OP_W-1:0] OP_NEQ  = OP_W'(8'h13);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(8'h14);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(8'h15);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(8'h16);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(8'h17);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIVIDE = 2'd1, S_WRBACK = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic                done_q, done_d;
    logic [1:0]          err_q, err_d;
    logic [DATA_W-1:0]   stack_q [DEPTH];
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx, tos_idx, nos_idx, push_idx;
    logic [DATA_W-1:0]   wr_data, a, b, alu;

    assign tos_idx  = IDX_W'(sp_q - SP_W'(1));
    assign nos_idx  = IDX_W'(sp_q - SP_W'(2));
    assign push_idx = IDX_W'(sp_q);
    assign a        = stack_q[nos_idx];
    assign b        = stack_q[tos_idx];

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_done  = done_q;
    assign rsp_err   = err_q;
    assign tos       = (sp_q == '0) ? '0 : b;
    assign depth     = sp_q;
    assign dbg_state = state_q;

`ifdef STACK_EXEC_DIV_EN
    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] rem_q, quo_q, dvs_q, rem_next;
    logic [DATA_W:0]   shift_rem;
    logic [CNT_W-1:0]  cnt_q;
    logic              is_mod_q, no_borrow, div_start;

    // Restoring step; a zero divisor never borrows, giving all-ones quotient and remainder a.
    assign shift_rem = {rem_q, quo_q[DATA_W-1]};
    assign no_borrow = (shift_rem >= {1'b0, dvs_q});
    assign rem_next  = no_borrow ? (shift_rem[DATA_W-1:0] - dvs_q) : shift_rem[DATA_W-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            is_mod_q <= 1'b0;
        end else if (div_start) begin
            rem_q    <= '0;
            quo_q    <= a;
            dvs_q    <= b;
            cnt_q    <= '0;
            is_mod_q <= (cmd_op == OP_MOD);
        end else if (state_q == S_DIVIDE) begin
            rem_q <= rem_next;
            quo_q <= {quo_q[DATA_W-2:0], no_borrow};
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`endif

    always_comb begin
        alu = '0;
        case (cmd_op)
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            OP_MUL:  alu = a * b;
            OP_GRET: alu = DATA_W'(a > b);
            OP_LESS: alu = DATA_W'(a < b);
            OP_EQ:   alu = DATA_W'(a == b);
            OP_NEQ:  alu = DATA_W'(a != b);
            OP_AND:  alu = a & b;
            OP_OR:   alu = a | b;
            OP_XOR:  alu = a ^ b;
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        done_d  = 1'b0;
        err_d   = 2'd0;
        wr_en   = 1'b0;
        wr_idx  = tos_idx;
        wr_data = '0;
`ifdef STACK_EXEC_DIV_EN
        div_start = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    done_d = 1'b1;
                    case (cmd_op)
                        OP_IGN: begin
                            if (sp_q == '0) err_d = 2'd1;
                            else            sp_d  = sp_q - SP_W'(1);
                        end
                        OP_IMM: begin
                            if (sp_q == SP_W'(DEPTH)) begin
                                err_d = 2'd2;
                            end else begin
                                wr_en   = 1'b1;
                                wr_idx  = push_idx;
                                wr_data = cmd_imm;
                                sp_d    = sp_q + SP_W'(1);
                            end
                        end
                        OP_NOT: begin
                            if (sp_q == '0) begin
                                err_d = 2'd1;
                            end else begin
                                wr_en   = 1'b1;
                                wr_data = ~b;
                            end
                        end
                        OP_ADD, OP_SUB, OP_MUL, OP_GRET, OP_LESS, OP_EQ,
                        OP_NEQ, OP_AND, OP_OR, OP_XOR: begin
                            if (sp_q < SP_W'(2)) begin
                                err_d = 2'd1;
                            end else begin
                                wr_en   = 1'b1;
                                wr_idx  = nos_idx;
                                wr_data = alu;
                                sp_d    = sp_q - SP_W'(1);
                            end
                        end
                        OP_DIV, OP_MOD: begin
`ifdef STACK_EXEC_DIV_EN
                            if (sp_q < SP_W'(2)) begin
                                err_d = 2'd1;
                            end else begin
                                done_d    = 1'b0;
                                div_start = 1'b1;
                                state_d   = S_DIVIDE;
                            end
`else
                            err_d = 2'd3;
`endif
                        end
                        default: err_d = 2'd3;
                    endcase
                end
            end
`ifdef STACK_EXEC_DIV_EN
            S_DIVIDE: begin
                if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_WRBACK;
            end
            S_WRBACK: begin
                wr_en   = 1'b1;
                wr_idx  = nos_idx;
                wr_data = is_mod_q ? rem_q : quo_q;
                sp_d    = sp_q - SP_W'(1);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sp_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Stack contents need no reset; sp alone defines what is valid.
    always_ff @(posedge clock) begin
        if (wr_en) stack_q[wr_idx] <= wr_data;
    end
endmodule

// File: tb/tb_stack_exec_unit.sv
// Self-checking bench for stack_exec_unit: model stack plus a response scoreboard.
// Covers the STACK_EXEC_DIV_EN build and the default build.
module tb_stack_exec_unit;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int OP_W   = 16;
    localparam int SP_W   = $clog2(DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op = '0;
    logic [DATA_W-1:0] cmd_imm = '0;
    logic              rsp_done;
    logic [1:0]        rsp_err;
    logic [DATA_W-1:0] tos;
    logic [SP_W-1:0]   depth;
    logic [1:0]        dbg_state;

    int total = 0;
    int bad   = 0;
    logic [1:0]        exp_q[$];
    logic [DATA_W-1:0] m_stk[$];

    stack_exec_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OP_W(OP_W)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_imm(cmd_imm), .rsp_done(rsp_done), .rsp_err(rsp_err),
        .tos(tos), .depth(depth), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    // Scoreboard: every rsp_done pops one expected error code.
    always @(negedge clock) begin
        logic [1:0] e;
        if (!reset && rsp_done) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got rsp_done err=%0d, required no response", rsp_err);
            end else begin
                e = exp_q.pop_front();
                if (rsp_err !== e) begin
                    bad++;
                    $display("FAIL rsp_err: got %0d, required %0d", rsp_err, e);
                end
            end
        end
    end

    task automatic do_reset();
        cmd_valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        m_stk.delete();
    endtask

    task automatic issue(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] imm);
        logic [1:0] e;
        logic [DATA_W-1:0] a, b, r;
        logic is_bin;
        int n;
        n = 0;
        @(negedge clock);
        while (!cmd_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL issue_ready_timeout: cmd_ready=%0b, required 1", cmd_ready);
            return;
        end
        e = 2'd0;
        r = '0;
        is_bin = (op >= 16'h0b && op <= 16'h16);
`ifndef STACK_EXEC_DIV_EN
        if (op == 16'h0e || op == 16'h0f) is_bin = 1'b0;
`endif
        if (op == 16'h00) begin
            if (m_stk.size() == 0) e = 2'd1;
            else void'(m_stk.pop_back());
        end else if (op == 16'h01) begin
            if (m_stk.size() == DEPTH) e = 2'd2;
            else m_stk.push_back(imm);
        end else if (op == 16'h17) begin
            if (m_stk.size() == 0) e = 2'd1;
            else m_stk[m_stk.size()-1] = ~m_stk[m_stk.size()-1];
        end else if (is_bin) begin
            if (m_stk.size() < 2) begin
                e = 2'd1;
            end else begin
                b = m_stk.pop_back();
                a = m_stk.pop_back();
                case (op)
                    16'h0b: r = a + b;
                    16'h0c: r = a - b;
                    16'h0d: r = a * b;
                    16'h0e: r = (b == 0) ? '1 : a / b;
                    16'h0f: r = (b == 0) ? a : a % b;
                    16'h10: r = (a > b) ? DATA_W'(1) : '0;
                    16'h11: r = (a < b) ? DATA_W'(1) : '0;
                    16'h12: r = (a == b) ? DATA_W'(1) : '0;
                    16'h13: r = (a != b) ? DATA_W'(1) : '0;
                    16'h14: r = a & b;
                    16'h15: r = a | b;
                    default: r = a ^ b;
                endcase
                m_stk.push_back(r);
            end
        end else begin
            e = 2'd3;
        end
        exp_q.push_back(e);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_imm = imm;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(cmd_ready && exp_q.size() == 0) && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!(cmd_ready && exp_q.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: pending=%0d cmd_ready=%0b, required 0 and 1", exp_q.size(), cmd_ready);
            exp_q.delete();
        end
    endtask

    task automatic check_state(input string tag);
        logic [DATA_W-1:0] et;
        @(negedge clock);
        et = (m_stk.size() == 0) ? '0 : m_stk[m_stk.size()-1];
        total += 2;
        if (depth !== SP_W'(m_stk.size())) begin
            bad++;
            $display("FAIL %s_depth: got %0d, required %0d", tag, depth, m_stk.size());
        end
        if (tos !== et) begin
            bad++;
            $display("FAIL %s_tos: got %h, required %h", tag, tos, et);
        end
    endtask

    task automatic expect_top(input string tag, input logic [DATA_W-1:0] et, input int ed);
        total += 2;
        if (tos !== et) begin
            bad++;
            $display("FAIL %s_tos_const: got %h, required %h", tag, tos, et);
        end
        if (depth !== SP_W'(ed)) begin
            bad++;
            $display("FAIL %s_depth_const: got %0d, required %0d", tag, depth, ed);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total += 5;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b, required 1", cmd_ready); end
        if (rsp_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b, required 0", rsp_done); end
        if (rsp_err !== 2'd0) begin bad++; $display("FAIL reset_err: got %0d, required 0", rsp_err); end
        if (tos !== '0) begin bad++; $display("FAIL reset_tos: got %h, required 0", tos); end
        if (depth !== '0) begin bad++; $display("FAIL reset_depth: got %0d, required 0", depth); end
    endtask

    task automatic test_add();
        do_reset();
        issue(16'h01, 16'd5);
        issue(16'h01, 16'd3);
        issue(16'h0b, 16'd0);
        wait_idle();
        check_state("add");
        expect_top("add", 16'd8, 1);
    endtask

    task automatic test_sub_eq();
        do_reset();
        issue(16'h01, 16'd3);
        issue(16'h01, 16'd5);
        issue(16'h0c, 16'd0);
        wait_idle();
        check_state("sub");
        expect_top("sub", 16'hfffe, 1);
        issue(16'h01, 16'hfffe);
        issue(16'h12, 16'd0);
        wait_idle();
        check_state("eq");
        expect_top("eq", 16'd1, 1);
    endtask

    task automatic test_underflow();
        do_reset();
        issue(16'h0b, 16'd0);
        issue(16'h00, 16'd0);
        issue(16'h17, 16'd0);
        wait_idle();
        expect_top("underflow_empty", 16'd0, 0);
        issue(16'h01, 16'd4);
        issue(16'h0c, 16'd0);
        wait_idle();
        check_state("underflow_one");
        expect_top("underflow_one", 16'd4, 1);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) issue(16'h01, DATA_W'($urandom_range(0, 65535)));
        wait_idle();
        check_state("fill");
        issue(16'h01, 16'h7777);
        wait_idle();
        check_state("overflow");
        total++;
        if (depth !== SP_W'(DEPTH)) begin
            bad++;
            $display("FAIL overflow_depth_const: got %0d, required %0d", depth, DEPTH);
        end
        issue(16'h0b, 16'd0);
        wait_idle();
        check_state("full_binop");
    endtask

    task automatic test_illegal();
        do_reset();
        issue(16'h01, 16'h1234);
        issue(16'h01, 16'h0055);
        issue(16'h0002, 16'd0);
        issue(16'h00ff, 16'd0);
        issue(16'h0112, 16'd0);
        wait_idle();
        check_state("illegal");
        expect_top("illegal", 16'h0055, 2);
    endtask

    task automatic test_back_to_back();
        logic [OP_W-1:0] ops [16];
        ops = '{16'h01, 16'h01, 16'h01, 16'h00, 16'h0b, 16'h0c, 16'h0d, 16'h10,
                16'h11, 16'h12, 16'h13, 16'h14, 16'h15, 16'h16, 16'h17, 16'h0f};
        do_reset();
        for (int i = 0; i < 30; i++)
            issue(ops[$urandom_range(0, 15)], DATA_W'($urandom_range(0, 65535)));
        wait_idle();
        check_state("b2b");
    endtask

    task automatic test_random();
        logic [OP_W-1:0] ops [17];
        logic [DATA_W-1:0] imm;
        ops = '{16'h01, 16'h01, 16'h01, 16'h00, 16'h0b, 16'h0c, 16'h0d, 16'h0e, 16'h0f,
                16'h10, 16'h11, 16'h12, 16'h13, 16'h14, 16'h15, 16'h16, 16'h17};
        do_reset();
        for (int i = 0; i < 50; i++) begin
            imm = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom_range(0, 2))
                                              : DATA_W'($urandom_range(0, 65535));
            issue(ops[$urandom_range(0, 16)], imm);
            wait_idle();
            check_state("rand");
        end
    endtask

`ifdef STACK_EXEC_DIV_EN
    task automatic test_divide();
        int n;
        do_reset();
        issue(16'h01, 16'd100);
        issue(16'h01, 16'd7);
        issue(16'h0e, 16'd0);
        n = 0;
        @(negedge clock);
        total++;
        if (dbg_state !== 2'd1) begin bad++; $display("FAIL div_state: got %0d, required 1", dbg_state); end
        while (!cmd_ready && n < 100) begin
            n++;
            @(negedge clock);
        end
        total++;
        if (n != DATA_W + 1) begin bad++; $display("FAIL div_busy_cycles: got %0d, required %0d", n, DATA_W + 1); end
        wait_idle();
        check_state("div");
        expect_top("div", 16'd14, 1);
        do_reset();
        issue(16'h01, 16'd100);
        issue(16'h01, 16'd7);
        issue(16'h0f, 16'd0);
        wait_idle();
        check_state("mod");
        expect_top("mod", 16'd2, 1);
        issue(16'h01, 16'd9);
        issue(16'h01, 16'd0);
        issue(16'h0e, 16'd0);
        wait_idle();
        check_state("div0");
        expect_top("div0", 16'hffff, 2);
        issue(16'h01, 16'd0);
        issue(16'h0f, 16'd0);
        wait_idle();
        check_state("mod0");
        expect_top("mod0", 16'hffff, 2);
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        issue(16'h01, 16'd50);
        issue(16'h01, 16'd5);
        issue(16'h0e, 16'd0);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        m_stk.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        total += 2;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b, required 1", cmd_ready); end
        if (depth !== '0) begin bad++; $display("FAIL abort_depth: got %0d, required 0", depth); end
        repeat (30) @(negedge clock);
        check_state("abort");
    endtask
`else
    task automatic test_divide();
        do_reset();
        issue(16'h01, 16'd100);
        issue(16'h01, 16'd7);
        issue(16'h0e, 16'd0);
        @(negedge clock);
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL nodiv_ready: got %b, required 1", cmd_ready); end
        issue(16'h0f, 16'd0);
        wait_idle();
        check_state("nodiv");
        expect_top("nodiv", 16'd7, 2);
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        issue(16'h01, 16'd1);
        issue(16'h0e, 16'd0);
        wait_idle();
        total++;
        if (dbg_state !== 2'd0) begin bad++; $display("FAIL nodiv_state: got %0d, required 0", dbg_state); end
        check_state("nodiv_under");
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub_eq();
        test_underflow();
        test_overflow();
        test_illegal();
        test_back_to_back();
        test_random();
        test_divide();
        test_reset_mid_div();
        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
